// File: rtl/mor1kx_tlb_reload_walker.sv
// Hardware page-table walker for the mor1kx I/D MMUs. On a TLB miss it reads the
// L1 PTE (and the L2 PTE unless the L1 entry is a huge page) over a req/ack bus,
// converts the PTE into TLB match/translate words and writes them into a victim way.
// Only OPTION_OPERAND_WIDTH = 32 is supported; the address slicing below assumes it.
module mor1kx_tlb_reload_walker #(
  parameter string       MMU_TYPE             = "DATA",
  parameter int unsigned OPTION_OPERAND_WIDTH = 32,
  parameter int unsigned OPTION_TLB_SET_WIDTH = 6,
  parameter int unsigned OPTION_TLB_WAYS      = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable_i,
  input  logic [21:0]                     ptbr_i,
  input  logic                            miss_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] miss_vaddr_i,
  input  logic [OPTION_TLB_WAYS-1:0]      way_valid_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            pagefault_o,
  input  logic                            pagefault_clear_i,
  output logic                            mem_req_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] mem_addr_o,
  input  logic                            mem_ack_i,
  input  logic                            mem_err_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] mem_data_i,
  output logic                            tlb_we_o,
  output logic [1:0]                      tlb_way_o,
  output logic [OPTION_TLB_SET_WIDTH-1:0] tlb_set_o,
  output logic                            tlb_huge_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] tlb_match_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] tlb_trans_o
);

  localparam int unsigned SetW    = OPTION_TLB_SET_WIDTH;
  localparam int unsigned Ways    = OPTION_TLB_WAYS;
  localparam int unsigned NumSets = 1 << SetW;
  localparam bit          IsInstr = (MMU_TYPE == "INSTR");

  // PTE bit positions
  localparam int unsigned PteU = 6;
  localparam int unsigned PteW = 7;
  localparam int unsigned PteX = 8;
  localparam int unsigned PteL = 9;
  localparam int unsigned PteP = 10;

  typedef enum logic [2:0] {
    StIdle,
    StL1,
    StL2,
    StWrite,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [31:13] vaddr_q, vaddr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] pte_q, pte_d;
  logic        huge_q, huge_d;
  logic        free_q, free_d;
  logic [1:0]  free_way_q, free_way_d;
  logic        pagefault_q, pagefault_d;
  logic [1:0]  rr_q [NumSets];

  logic            abort;
  logic            accept;
  logic            fault;
  logic            free_found;
  logic [1:0]      free_way;
  logic            write_en;
  logic [SetW-1:0] wr_set;
  logic [1:0]      rr_cur;
  logic [1:0]      rr_next;
  logic            rr_advance;
  logic [1:0]      victim;
  logic [31:0]     trans;
  logic            unused_bits;

  // Walking is only legal with the MMU on and a page table configured.
  assign abort  = !enable_i || (ptbr_i == '0);
  // Reset is folded in so every output reads 0 while reset is asserted.
  assign accept = rst_n && (state_q == StIdle) && miss_i && !abort && !pagefault_q;

  // Lowest-index invalid way of the indexed set, sampled when the miss is accepted.
  always_comb begin
    free_found = 1'b0;
    free_way   = '0;
    for (int i = int'(Ways) - 1; i >= 0; i--) begin
      if (!way_valid_i[i]) begin
        free_found = 1'b1;
        free_way   = 2'(i);
      end
    end
  end

  // Walk sequencing: bus reads, PTE checks, fault detection and abort.
  always_comb begin
    state_d    = state_q;
    vaddr_d    = vaddr_q;
    addr_d     = addr_q;
    pte_d      = pte_q;
    huge_d     = huge_q;
    free_d     = free_q;
    free_way_d = free_way_q;
    fault      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d    = StL1;
          vaddr_d    = miss_vaddr_i[31:13];
          addr_d     = {ptbr_i, miss_vaddr_i[31:24], 2'b00};
          huge_d     = 1'b0;
          free_d     = free_found;
          free_way_d = free_way;
        end
      end
      StL1: begin
        if (abort) begin
          state_d = StIdle;
        end else if (mem_err_i) begin
          fault   = 1'b1;
          state_d = StIdle;
        end else if (mem_ack_i) begin
          if (mem_data_i[31:13] == '0) begin
            fault   = 1'b1;
            state_d = StIdle;
          end else if (mem_data_i[PteL]) begin
            if (!mem_data_i[PteP]) begin
              fault   = 1'b1;
              state_d = StIdle;
            end else begin
              pte_d   = mem_data_i;
              huge_d  = 1'b1;
              state_d = StWrite;
            end
          end else begin
            addr_d  = {mem_data_i[31:13], vaddr_q[23:13], 2'b00};
            state_d = StL2;
          end
        end
      end
      StL2: begin
        if (abort) begin
          state_d = StIdle;
        end else if (mem_err_i) begin
          fault   = 1'b1;
          state_d = StIdle;
        end else if (mem_ack_i) begin
          if (!mem_data_i[PteP]) begin
            fault   = 1'b1;
            state_d = StIdle;
          end else begin
            pte_d   = mem_data_i;
            state_d = StWrite;
          end
        end
      end
      StWrite: state_d = abort ? StIdle : StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Sticky fault flag; a clear beats a fault raised in the same cycle.
  always_comb begin
    pagefault_d = pagefault_q;
    if (pagefault_clear_i) begin
      pagefault_d = 1'b0;
    end else if (fault) begin
      pagefault_d = 1'b1;
    end
  end

  // Walk state and latched miss context.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      vaddr_q     <= '0;
      addr_q      <= '0;
      pte_q       <= '0;
      huge_q      <= 1'b0;
      free_q      <= 1'b0;
      free_way_q  <= '0;
      pagefault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vaddr_q     <= vaddr_d;
      addr_q      <= addr_d;
      pte_q       <= pte_d;
      huge_q      <= huge_d;
      free_q      <= free_d;
      free_way_q  <= free_way_d;
      pagefault_q <= pagefault_d;
    end
  end

  // Victim choice; huge pages index the pointer table with the huge set index.
  always_comb begin
    write_en   = (state_q == StWrite) && !abort;
    wr_set     = huge_q ? vaddr_q[24 +: SetW] : vaddr_q[13 +: SetW];
    rr_cur     = rr_q[wr_set];
    rr_next    = (int'(rr_cur) >= int'(Ways) - 1) ? 2'd0 : rr_cur + 2'd1;
    rr_advance = write_en && !free_q;
    victim     = free_q ? free_way_q : rr_cur;
  end

  // Per-set round-robin pointers, stepped only when a write consumed them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NumSets); i++) begin
        rr_q[i] <= '0;
      end
    end else if (rr_advance) begin
      rr_q[wr_set] <= rr_next;
    end
  end

  // PTE to translate word; permission mapping depends on which MMU this serves.
  always_comb begin
    trans        = '0;
    trans[31:13] = pte_q[31:13];
    trans[5:0]   = pte_q[5:0];
    if (IsInstr) begin
      trans[7] = pte_q[PteX];
      trans[6] = pte_q[PteX] & pte_q[PteU];
    end else begin
      trans[9] = pte_q[PteW];
      trans[8] = 1'b1;
      trans[7] = pte_q[PteW] & pte_q[PteU];
      trans[6] = pte_q[PteU];
    end
  end

  // Outputs; TLB fields are zero outside the write cycle.
  always_comb begin
    busy_o      = accept || (state_q != StIdle);
    done_o      = (state_q == StDone);
    pagefault_o = pagefault_q;
    mem_req_o   = ((state_q == StL1) || (state_q == StL2)) && !abort;
    mem_addr_o  = addr_q;
    tlb_we_o    = write_en;
    tlb_way_o   = write_en ? victim : 2'd0;
    tlb_set_o   = write_en ? wr_set : '0;
    tlb_huge_o  = write_en && huge_q;
    tlb_match_o = write_en ? {vaddr_q, 12'b0, 1'b1} : '0;
    tlb_trans_o = write_en ? trans : '0;
  end

  assign unused_bits = ^{miss_vaddr_i[12:0], pte_q[12:6]};

endmodule

// File: tb/tb_mor1kx_tlb_reload_walker.sv
// Randomised self-checking bench for the TLB reload walker: a DATA instance with four
// ways is fully checked; an INSTR instance shares the stimulus for permission mapping.
module tb_mor1kx_tlb_reload_walker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic [21:0] ptbr = 22'h1;
  logic        miss = 1'b0;
  logic [31:0] miss_vaddr = '0;
  logic [3:0]  way_valid = '0;
  logic        pf_clear = 1'b0;
  logic        mem_ack = 1'b0;
  logic        mem_err = 1'b0;
  logic [31:0] mem_data = '0;

  logic        busy, done, pf, mem_req, tlb_we, tlb_huge;
  logic [31:0] mem_addr, tlb_match, tlb_trans;
  logic [1:0]  tlb_way;
  logic [5:0]  tlb_set;
  logic        i_busy, i_done, i_pf, i_mem_req, i_tlb_we, i_tlb_huge;
  logic [31:0] i_mem_addr, i_tlb_match, i_tlb_trans;
  logic [1:0]  i_tlb_way;
  logic [5:0]  i_tlb_set;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mor1kx_tlb_reload_walker #(
    .MMU_TYPE("DATA"), .OPTION_OPERAND_WIDTH(32), .OPTION_TLB_SET_WIDTH(6), .OPTION_TLB_WAYS(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .ptbr_i(ptbr), .miss_i(miss),
    .miss_vaddr_i(miss_vaddr), .way_valid_i(way_valid), .busy_o(busy), .done_o(done),
    .pagefault_o(pf), .pagefault_clear_i(pf_clear), .mem_req_o(mem_req), .mem_addr_o(mem_addr),
    .mem_ack_i(mem_ack), .mem_err_i(mem_err), .mem_data_i(mem_data), .tlb_we_o(tlb_we),
    .tlb_way_o(tlb_way), .tlb_set_o(tlb_set), .tlb_huge_o(tlb_huge), .tlb_match_o(tlb_match),
    .tlb_trans_o(tlb_trans)
  );

  mor1kx_tlb_reload_walker #(
    .MMU_TYPE("INSTR"), .OPTION_OPERAND_WIDTH(32), .OPTION_TLB_SET_WIDTH(6), .OPTION_TLB_WAYS(2)
  ) dut_i (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .ptbr_i(ptbr), .miss_i(miss),
    .miss_vaddr_i(miss_vaddr), .way_valid_i(way_valid[1:0]), .busy_o(i_busy), .done_o(i_done),
    .pagefault_o(i_pf), .pagefault_clear_i(pf_clear), .mem_req_o(i_mem_req),
    .mem_addr_o(i_mem_addr), .mem_ack_i(mem_ack), .mem_err_i(mem_err), .mem_data_i(mem_data),
    .tlb_we_o(i_tlb_we), .tlb_way_o(i_tlb_way), .tlb_set_o(i_tlb_set), .tlb_huge_o(i_tlb_huge),
    .tlb_match_o(i_tlb_match), .tlb_trans_o(i_tlb_trans)
  );

  // Reference model state and expectations
  logic [1:0]  rr_m [64];
  logic        e_fault, e_huge;
  int          e_nreads;
  logic [31:0] e_l1, e_l2, e_trans, e_itrans, e_match;
  logic [5:0]  e_set;
  logic [1:0]  e_way;

  // Observations from one walk
  int          o_nreads, o_we, o_done;
  logic        o_timeout, o_busy_acc, o_huge;
  logic [31:0] o_l1, o_l2, o_match, o_trans, o_itrans;
  logic [5:0]  o_set;
  logic [1:0]  o_way;

  // Expected outcome of a walk computed straight from the page-table rules.
  task automatic model_walk(input logic [21:0] pt, input logic [31:0] va, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [3:0] wv, input int err_lvl);
    logic [31:0] pte;
    int w, u, x, free;
    e_fault  = 1'b0;
    e_huge   = 1'b0;
    e_nreads = 1;
    e_l2     = '0;
    e_l1     = 32'(pt) * 1024 + (va >> 24) * 4;
    pte      = '0;
    if (err_lvl == 1 || (d1 >> 13) == 0) begin
      e_fault = 1'b1;
    end else if (d1[9]) begin
      e_huge = 1'b1;
      pte    = d1;
      if (!d1[10]) e_fault = 1'b1;
    end else begin
      e_nreads = 2;
      e_l2     = (d1 & 32'hFFFF_E000) + ((va >> 13) % 2048) * 4;
      pte      = d2;
      if (err_lvl == 2 || !d2[10]) e_fault = 1'b1;
    end
    e_set    = e_huge ? 6'((va >> 24) % 64) : 6'((va >> 13) % 64);
    w        = int'(pte[7]);
    u        = int'(pte[6]);
    x        = int'(pte[8]);
    e_trans  = (pte & 32'hFFFF_E000) | (pte & 32'h3F) | 32'(w * 512 + 256 + w * u * 128 + u * 64);
    e_itrans = (pte & 32'hFFFF_E000) | (pte & 32'h3F) | 32'(x * 128 + x * u * 64);
    e_match  = (va & 32'hFFFF_E000) | 32'h1;
    free     = -1;
    for (int i = 3; i >= 0; i--) if (!wv[i]) free = i;
    e_way = '0;
    if (!e_fault) begin
      if (free >= 0) begin
        e_way = 2'(free);
      end else begin
        e_way        = rr_m[e_set];
        rr_m[e_set]  = 2'((int'(rr_m[e_set]) + 1) % 4);
      end
    end
  endtask

  // Drives one miss and acts as the bus slave; records what the DUT did.
  task automatic run_walk(input logic [31:0] va, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [3:0] wv, input int err_lvl, input logic clr);
    int cyc;
    o_nreads = 0; o_we = 0; o_done = 0; o_timeout = 1'b0; o_huge = 1'b0;
    o_l1 = '0; o_l2 = '0; o_match = '0; o_trans = '0; o_itrans = '0; o_set = '0; o_way = '0;
    @(negedge clk);
    miss = 1'b1; miss_vaddr = va; way_valid = wv; pf_clear = clr;
    #1 o_busy_acc = busy;
    @(negedge clk);
    miss = 1'b0;
    way_valid = 4'($urandom);
    cyc = 0;
    while (busy && cyc < 64) begin
      if (mem_ack || mem_err) begin
        mem_ack = 1'b0; mem_err = 1'b0; mem_data = $urandom;
      end else if (mem_req && $urandom_range(0, 2) != 0) begin
        if (o_nreads == 0) o_l1 = mem_addr;
        else o_l2 = mem_addr;
        if (err_lvl == o_nreads + 1) mem_err = 1'b1;
        else mem_ack = 1'b1;
        mem_data = (o_nreads == 0) ? d1 : d2;
        o_nreads++;
      end
      if (tlb_we) begin
        o_we++; o_way = tlb_way; o_set = tlb_set; o_huge = tlb_huge;
        o_match = tlb_match; o_trans = tlb_trans;
      end
      if (i_tlb_we) o_itrans = i_tlb_trans;
      if (done) o_done++;
      @(negedge clk);
      cyc++;
    end
    mem_ack = 1'b0; mem_err = 1'b0; pf_clear = 1'b0;
    o_timeout = (cyc >= 64);
  endtask

  task automatic pulse_clear();
    @(negedge clk); pf_clear = 1'b1;
    @(negedge clk); pf_clear = 1'b0;
  endtask

  task automatic test_reset();
    miss = 1'b1;
    miss_vaddr = 32'h0040_2000;
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin
      errors++; $display("FAIL reset_bus got req=%b addr=%h want 0/0", mem_req, mem_addr);
    end
    checks++; if ({done, pf, tlb_we, tlb_huge, tlb_way, tlb_set} !== '0 ||
                  tlb_match !== 32'h0 || tlb_trans !== 32'h0) begin
      errors++; $display("FAIL reset_outputs got we=%b match=%h trans=%h want 0", tlb_we,
                         tlb_match, tlb_trans);
    end
    @(negedge clk);
    miss = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) rr_m[i] = '0;
    #1;
    checks++; if (busy !== 1'b0 || i_busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle got busy=%b/%b want 0", busy, i_busy);
    end
  endtask

  task automatic test_normal_walk();
    ptbr = 22'h1;
    model_walk(ptbr, 32'h0040_2000, 32'h0000_4000, 32'h1234_A4C0, 4'b0000, 0);
    run_walk(32'h0040_2000, 32'h0000_4000, 32'h1234_A4C0, 4'b0000, 0, 1'b0);
    checks++; if (o_busy_acc !== 1'b1) begin
      errors++; $display("FAIL normal_accept_busy got %b want 1", o_busy_acc);
    end
    checks++; if (o_l1 !== 32'h0000_0400) begin
      errors++; $display("FAIL normal_l1_addr got %h want 00000400", o_l1);
    end
    checks++; if (o_l2 !== e_l2 || o_nreads != 2) begin
      errors++; $display("FAIL normal_l2_addr got %h/%0d want %h/2", o_l2, o_nreads, e_l2);
    end
    checks++; if (o_trans !== 32'h1234_A3C0) begin
      errors++; $display("FAIL normal_trans got %h want 1234a3c0", o_trans);
    end
    checks++; if (o_match !== 32'h0040_2001 || o_set !== 6'd1 || o_huge !== 1'b0) begin
      errors++; $display("FAIL normal_match got %h set %0d huge %b want 00402001 1 0",
                         o_match, o_set, o_huge);
    end
    checks++; if (o_we != 1 || o_done != 1 || o_timeout) begin
      errors++; $display("FAIL normal_strobes got we=%0d done=%0d to=%b want 1 1 0",
                         o_we, o_done, o_timeout);
    end
    checks++; if (o_itrans !== e_itrans) begin
      errors++; $display("FAIL normal_instr_trans got %h want %h", o_itrans, e_itrans);
    end
  endtask

  task automatic test_huge();
    logic [31:0] va;
    va = 32'h2A00_0000 | ($urandom & 32'h00FF_FFFF);
    model_walk(ptbr, va, 32'h8000_0600, 32'h0, 4'b0000, 0);
    run_walk(va, 32'h8000_0600, 32'h0, 4'b0000, 0, 1'b0);
    checks++; if (o_nreads != 1 || o_huge !== 1'b1 || o_we != 1) begin
      errors++; $display("FAIL huge_walk got reads=%0d huge=%b we=%0d want 1 1 1",
                         o_nreads, o_huge, o_we);
    end
    checks++; if (o_set !== 6'h2A || o_set !== e_set) begin
      errors++; $display("FAIL huge_set got %h want 2a", o_set);
    end
    checks++; if (o_trans[31:24] !== 8'h80 || o_trans !== e_trans) begin
      errors++; $display("FAIL huge_trans got %h want %h", o_trans, e_trans);
    end
  endtask

  task automatic test_faults();
    logic [31:0] d1s [4] = '{32'h0000_0000, 32'h0000_4000, 32'h0000_4000, 32'h8000_0200};
    logic [31:0] d2s [4] = '{32'h0, 32'h1234_A0C0, 32'h1234_A4C0, 32'h0};
    int          errl [4] = '{0, 0, 2, 0};
    for (int k = 0; k < 4; k++) begin
      model_walk(ptbr, 32'h0300_6000, d1s[k], d2s[k], 4'b1111, errl[k]);
      run_walk(32'h0300_6000, d1s[k], d2s[k], 4'b1111, errl[k], 1'b0);
      checks++; if (pf !== 1'b1 || o_we != 0 || o_done != 0 || o_nreads != e_nreads) begin
        errors++; $display("FAIL fault_%0d got pf=%b we=%0d reads=%0d want 1 0 %0d",
                           k, pf, o_we, o_nreads, e_nreads);
      end
      @(negedge clk); miss = 1'b1; miss_vaddr = 32'h0300_6000;
      for (int c = 0; c < 3; c++) begin
        #1;
        checks++; if (busy !== 1'b0 || mem_req !== 1'b0 || pf !== 1'b1) begin
          errors++; $display("FAIL fault_block_%0d got busy=%b req=%b pf=%b want 0 0 1",
                             k, busy, mem_req, pf);
        end
        @(negedge clk);
      end
      miss = 1'b0;
      pulse_clear();
      #1;
      checks++; if (pf !== 1'b0) begin
        errors++; $display("FAIL fault_clear_%0d got %b want 0", k, pf);
      end
    end
    // Clear held across the faulting ack must win.
    model_walk(ptbr, 32'h0300_6000, 32'h0, 32'h0, 4'b1111, 0);
    run_walk(32'h0300_6000, 32'h0, 32'h0, 4'b1111, 0, 1'b1);
    #1;
    checks++; if (pf !== 1'b0 || o_we != 0 || o_nreads != 1) begin
      errors++; $display("FAIL fault_clear_wins got pf=%b we=%0d want 0 0", pf, o_we);
    end
  endtask

  task automatic test_victim();
    logic [31:0] va, d1, d2;
    int exp_ways [5] = '{0, 1, 2, 3, 0};
    va = 32'h1100_0000 | (32'd5 << 13);
    d1 = ($urandom | 32'h2000) & ~32'h200;
    d2 = $urandom | 32'h400;
    model_walk(ptbr, va, d1, d2, 4'b1011, 0);
    run_walk(va, d1, d2, 4'b1011, 0, 1'b0);
    checks++; if (o_way !== 2'd2 || o_we != 1) begin
      errors++; $display("FAIL victim_free got way %0d we %0d want 2 1", o_way, o_we);
    end
    for (int k = 0; k < 5; k++) begin
      model_walk(ptbr, va, d1, d2, 4'b1111, 0);
      run_walk(va, d1, d2, 4'b1111, 0, 1'b0);
      checks++; if (o_way !== 2'(exp_ways[k]) || o_way !== e_way || o_set !== 6'd5) begin
        errors++; $display("FAIL victim_rr_%0d got way %0d set %0d want %0d 5",
                           k, o_way, o_set, exp_ways[k]);
      end
    end
  endtask

  task automatic test_abort();
    int wes;
    @(negedge clk);
    miss = 1'b1; miss_vaddr = 32'h0055_6000; way_valid = 4'b1111;
    @(negedge clk);
    miss = 1'b0; mem_ack = 1'b1; mem_data = 32'h0001_2000;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++; if (mem_req !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL abort_in_l2 got req=%b busy=%b want 1 1", mem_req, busy);
    end
    enable = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL abort_idle got busy=%b req=%b want 0 0", busy, mem_req);
    end
    enable = 1'b1; mem_ack = 1'b1; mem_data = 32'h0777_7400;
    wes = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (tlb_we || done || busy) wes++;
    end
    checks++; if (wes != 0 || pf !== 1'b0) begin
      errors++; $display("FAIL abort_late_ack got activity=%0d pf=%b want 0 0", wes, pf);
    end
    model_walk(ptbr, 32'h0055_6000, 32'h0001_2000, 32'h0777_7400, 4'b0111, 0);
    run_walk(32'h0055_6000, 32'h0001_2000, 32'h0777_7400, 4'b0111, 0, 1'b0);
    checks++; if (o_done != 1 || o_trans !== e_trans || o_way !== e_way) begin
      errors++; $display("FAIL abort_rewalk got done=%0d trans=%h way=%0d want 1 %h %0d",
                         o_done, o_trans, o_way, e_trans, e_way);
    end
  endtask

  task automatic test_instr_and_reset();
    model_walk(ptbr, 32'h0123_4000, 32'h0000_6000, 32'h0ABC_C580, 4'b0000, 0);
    run_walk(32'h0123_4000, 32'h0000_6000, 32'h0ABC_C580, 4'b0000, 0, 1'b0);
    checks++; if (o_itrans[7:6] !== 2'b10 || o_itrans[9:8] !== 2'b00 || o_itrans !== e_itrans) begin
      errors++; $display("FAIL instr_perm got %h want %h", o_itrans, e_itrans);
    end
    @(negedge clk);
    miss = 1'b1; miss_vaddr = 32'h0123_4000;
    @(negedge clk);
    miss = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({busy, done, pf, mem_req, tlb_we, tlb_huge, tlb_way, tlb_set} !== '0 ||
                  mem_addr !== 32'h0 || tlb_match !== 32'h0 || tlb_trans !== 32'h0 ||
                  i_busy !== 1'b0 || i_mem_req !== 1'b0) begin
      errors++; $display("FAIL async_reset got busy=%b req=%b addr=%h want 0 0 0",
                         busy, mem_req, mem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) rr_m[i] = '0;
    // Pointer of set 5 must be back at way 0.
    model_walk(ptbr, 32'h1100_0000 | (32'd5 << 13), 32'h0000_4000, 32'h0000_0400, 4'b1111, 0);
    run_walk(32'h1100_0000 | (32'd5 << 13), 32'h0000_4000, 32'h0000_0400, 4'b1111, 0, 1'b0);
    checks++; if (o_way !== 2'd0 || o_way !== e_way || o_done != 1) begin
      errors++; $display("FAIL reset_rr got way %0d done %0d want 0 1", o_way, o_done);
    end
  endtask

  task automatic test_random();
    logic [31:0] va, d1, d2;
    logic [3:0]  wv;
    int          kind, errl;
    for (int n = 0; n < 30; n++) begin
      ptbr = 22'($urandom_range(1, 22'h3F_FFFF));
      va   = $urandom;
      wv   = 4'($urandom);
      kind = $urandom_range(0, 9);
      if (kind == 0) d1 = $urandom & 32'h1FFF;
      else if (kind <= 3) d1 = $urandom | 32'h2200;
      else d1 = ($urandom | 32'h2000) & ~32'h200;
      d2   = ($urandom_range(0, 7) == 0) ? ($urandom & ~32'h400) : ($urandom | 32'h400);
      errl = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : 0;
      model_walk(ptbr, va, d1, d2, wv, errl);
      run_walk(va, d1, d2, wv, errl, 1'b0);
      checks++; if (o_timeout || o_l1 !== e_l1 || o_nreads != e_nreads ||
                    (e_nreads == 2 && o_l2 !== e_l2)) begin
        errors++; $display("FAIL rand_bus_%0d got l1=%h l2=%h reads=%0d want %h %h %0d",
                           n, o_l1, o_l2, o_nreads, e_l1, e_l2, e_nreads);
      end
      if (e_fault) begin
        checks++; if (pf !== 1'b1 || o_we != 0 || o_done != 0) begin
          errors++; $display("FAIL rand_fault_%0d got pf=%b we=%0d want 1 0", n, pf, o_we);
        end
        pulse_clear();
      end else begin
        checks++; if (pf !== 1'b0 || o_we != 1 || o_done != 1 || o_trans !== e_trans ||
                      o_match !== e_match || o_set !== e_set || o_huge !== e_huge ||
                      o_way !== e_way || o_itrans !== e_itrans) begin
          errors++; $display("FAIL rand_write_%0d got trans=%h match=%h set=%0d huge=%b way=%0d itrans=%h want %h %h %0d %b %0d %h",
                             n, o_trans, o_match, o_set, o_huge, o_way, o_itrans,
                             e_trans, e_match, e_set, e_huge, e_way, e_itrans);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_normal_walk();
    test_huge();
    test_faults();
    test_victim();
    test_abort();
    test_instr_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
